// File: rtl/instr_seq_encoder_if.sv
// Host command / instruction injection bundle for instr_seq_encoder.
// The master drives commands, flush and instr_ready; the slave is the encoder.
interface instr_seq_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_regno;
    logic [4:0]  cmd_addr_reg;
    logic [1:0]  cmd_size;
    logic        cmd_postinc;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        cmd_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_regno, cmd_addr_reg, cmd_size, cmd_postinc,
               flush, instr_ready,
        input  cmd_ready, instr_valid, instr, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_regno, cmd_addr_reg, cmd_size, cmd_postinc,
               flush, instr_ready,
        output cmd_ready, instr_valid, instr, cmd_done, cmd_err
    );
endinterface

// File: rtl/instr_seq_encoder.sv
// Encodes host debug commands (reg/mem read/write) into short RV64 instruction streams.
// Latency: first instr valid the cycle after accept, then 1 instr/cycle; done one cycle after last handshake.
// Backpressure: instr is held stable while instr_valid && !instr_ready; cmd_ready only in IDLE.
module instr_seq_encoder #(
    parameter logic [11:0] DATA_CSR    = 12'h7B2,
    parameter bit          TERM_EBREAK = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_seq_encoder_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, STEP_A, STEP_B, POSTINC, TERM} state_t;

    localparam logic [1:0]  OP_REG_READ = 2'd0;
    localparam logic [1:0]  OP_MEM_READ = 2'd2;
    localparam logic [1:0]  OP_MEM_WR   = 2'd3;
    localparam logic [31:0] EBREAK      = 32'h0010_0073;

    state_t      state;
    logic [1:0]  lat_op;
    logic [4:0]  lat_rd;
    logic [4:0]  lat_ra;
    logic [1:0]  lat_size;
    logic        lat_postinc;

    function automatic logic [31:0] enc(state_t st, logic [1:0] op, logic [4:0] rd,
                                        logic [4:0] ra, logic [1:0] sz);
        logic [31:0] csr_rd;
        logic [31:0] csr_wr;
        logic [31:0] ld;
        logic [31:0] st_w;
        logic [31:0] addi;
        csr_rd = {DATA_CSR, rd, 3'b001, 5'd0, 7'h73};
        csr_wr = {DATA_CSR, 5'd0, 3'b010, rd, 7'h73};
        ld     = {12'd0, ra, 1'b0, sz, rd, 7'h03};
        st_w   = {7'd0, rd, ra, 1'b0, sz, 5'd0, 7'h23};
        addi   = {12'd1 << sz, ra, 3'b000, ra, 7'h13};
        case (st)
            STEP_A:  enc = (op == OP_REG_READ) ? csr_rd : (op == OP_MEM_READ) ? ld : csr_wr;
            STEP_B:  enc = (op == OP_MEM_WR) ? st_w : csr_rd;
            POSTINC: enc = addi;
            TERM:    enc = EBREAK;
            default: enc = 32'd0;
        endcase
    endfunction

    function automatic state_t nxt(state_t st, logic [1:0] op, logic pi);
        state_t tail;
        tail = TERM_EBREAK ? TERM : IDLE;
        case (st)
            STEP_A:  nxt = op[1] ? STEP_B : tail;
            STEP_B:  nxt = pi ? POSTINC : tail;
            POSTINC: nxt = tail;
            default: nxt = IDLE;
        endcase
    endfunction

    logic   accept;
    logic   reject;
    state_t next_st;

    assign bus.cmd_ready = (state == IDLE);
    assign accept  = bus.cmd_valid && (state == IDLE) && !bus.flush;
    // Post-increment of x0 or of the data register would corrupt the transfer.
    assign reject  = bus.cmd_op[1] && bus.cmd_postinc &&
                     ((bus.cmd_addr_reg == bus.cmd_regno) || (bus.cmd_addr_reg == 5'd0));
    assign next_st = nxt(state, lat_op, lat_postinc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            lat_op          <= 2'd0;
            lat_rd          <= 5'd0;
            lat_ra          <= 5'd0;
            lat_size        <= 2'd0;
            lat_postinc     <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.instr       <= 32'd0;
            bus.cmd_done    <= 1'b0;
            bus.cmd_err     <= 1'b0;
        end else begin
            bus.cmd_done <= 1'b0;
            bus.cmd_err  <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    lat_op      <= bus.cmd_op;
                    lat_rd      <= bus.cmd_regno;
                    lat_ra      <= bus.cmd_addr_reg;
                    lat_size    <= bus.cmd_size;
                    lat_postinc <= bus.cmd_postinc;
                    if (reject) begin
                        bus.cmd_done <= 1'b1;
                        bus.cmd_err  <= 1'b1;
                    end else begin
                        state           <= STEP_A;
                        bus.instr_valid <= 1'b1;
                        bus.instr       <= enc(STEP_A, bus.cmd_op, bus.cmd_regno,
                                               bus.cmd_addr_reg, bus.cmd_size);
                    end
                end
            end else if (bus.flush) begin
                state           <= IDLE;
                bus.instr_valid <= 1'b0;
            end else if (bus.instr_valid && bus.instr_ready) begin
                state <= next_st;
                if (next_st == IDLE) begin
                    bus.instr_valid <= 1'b0;
                    bus.cmd_done    <= 1'b1;
                end else begin
                    bus.instr <= enc(next_st, lat_op, lat_rd, lat_ra, lat_size);
                end
            end
        end
    end
endmodule
